div_sequencer: RTL and testbench
================================

# div_sequencer

Controller that sequences the multicycle `div` datapath for signed DIV instructions. It latches operands from the CPU control unit and converts them to magnitudes. It holds the divider's control line for exactly the required number of cycles, then captures and sign-corrects the quotient and remainder into the HI/LO registers. It sits between the main control FSM and `div`, and reports busy, done and divide-by-zero.

## Interface
Parameters:
- `DIV_CYCLES`, 33: cycles `div_control` stays high; the divider writes its results on the 33rd enabled edge.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `start`  in  1  request a signed division; accepted only in IDLE.
- `dividend`  in  32  signed dividend (rs); sampled on accept.
- `divisor`  in  32  signed divisor (rt); sampled on accept.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle pulse when the operation finishes.
- `div_by_zero`  out  1  valid with `done`; high if the divisor was 0.
- `hi`  out  32  remainder (MIPS HI); holds the last successful result.
- `lo`  out  32  quotient (MIPS LO); holds the last successful result.
- `div_control`  out  1  to `div.divControl`; registered.
- `div_a`  out  32  to `div.aInput`; dividend magnitude, stable while busy.
- `div_b`  out  32  to `div.bInput`; divisor magnitude, stable while busy.
- `div_hi`  in  32  from `div.HI` (unsigned remainder).
- `div_lo`  in  32  from `div.LO` (unsigned quotient).
- `div_err`  in  1  from `div.err`.

## Operation
States: IDLE, RUN, CAPTURE, FINISH, ZERO.

- **IDLE:** `div_control`=0. When `start`=1:
  - latch `div_a`=|dividend| and `div_b`=|divisor|, each in two's complement; 0x80000000 stays 0x80000000 and is treated as unsigned 2^31.
  - latch `neg_q` = dividend[31] XOR divisor[31] and `neg_r` = dividend[31].
  - go to RUN with `cnt`=0 and `div_control`=1.
- **RUN:** `div_control`=1; `cnt` increments each cycle.
  - If `div_err`=1 with `cnt`=1, go to ZERO and drop `div_control`.
  - When `cnt`=DIV_CYCLES−1, go to CAPTURE; `div_control` goes to 0 on that same edge.
- **CAPTURE:** `div_control`=0, which clears the divider's internal state.
  - `lo` ← neg_q ? −div_lo : div_lo.
  - `hi` ← neg_r ? −div_hi : div_hi. All arithmetic is 32-bit, wrap-around.
  - Go to FINISH.
- **FINISH:** `done`=1, `div_by_zero`=0, `busy`=0; go to IDLE.
- **ZERO:** `done`=1, `div_by_zero`=1, `busy`=0; `hi`/`lo` unchanged; go to IDLE.
- `start` in any state other than IDLE is ignored. It is not queued.
- `div_control` is low for at least one cycle between operations (CAPTURE or ZERO) so the divider's counter restarts at 0.
- `div_a`/`div_b` change only on accept. They are held stable throughout RUN, because the divider re-checks `bInput` every cycle.

## Timing
- Reset (`reset`=0 at an edge), in any state:
  - state IDLE and `cnt`=0.
  - `div_control`=0, `busy`=0, `done`=0, `div_by_zero`=0.
  - `hi`=0, `lo`=0, `div_a`=0, `div_b`=0.
  - Reset mid-operation aborts the operation with no `done`; the divider clears on the next edge because `div_control` is low.
- Let edge E be the edge that samples `start`=1 in IDLE:
  - `busy`=1 and `div_control`=1 during cycles E+1 … E+33, 33 cycles in total.
  - CAPTURE occurs in cycle E+34; `hi`/`lo` update at the end of E+34.
  - `done`=1 in cycle E+35; the new `hi`/`lo` are visible in the same cycle.
  - Start-to-done latency is 35 cycles.
- Divide by zero:
  - the divider sets `err` at the end of cycle E+1.
  - the sequencer sees `div_err`=1 in E+2 and goes to ZERO; `div_control`=0 from E+3.
  - `done`=1 and `div_by_zero`=1 in cycle E+3.
- Back-to-back: `start` held high through `done` is accepted in the first IDLE cycle after `done`, which is E+36. Minimum spacing is therefore 36 cycles.
- `start` and `reset`=0 in the same cycle: reset wins, and the request is dropped.

## Test plan
- Reset low 2 cycles, then 100 / 7 → `done` 35 cycles after accept, `lo`=14, `hi`=2, `div_by_zero`=0; `div_control` high exactly 33 cycles.
- −100 / 7 → `lo`=0xFFFFFFF2 (−14), `hi`=0xFFFFFFFE (−2). 100 / −7 → `lo`=0xFFFFFFF2, `hi`=2. −100 / −7 → `lo`=14, `hi`=0xFFFFFFFE.
- Load 100 / 7, then 55 / 0 → `done` and `div_by_zero`=1 three cycles after accept; `hi`=2 and `lo`=14 unchanged; `div_control` low from cycle E+3.
- 100 / 7 with `reset`=0 at cycle E+10 → no `done`; `hi`=`lo`=0; `busy`=0 and `div_control`=0 next cycle. A following 9 / 3 gives `lo`=3, `hi`=0.
- `start` pulsed again at E+5 with different operands → ignored; the result is for the first operands; `div_a`/`div_b` are stable for all of RUN.
- `start` held high continuously → 0xFFFFFFFF / 1 repeated: `lo`=0xFFFFFFFF (−1), `hi`=0, `done` every 36 cycles, `div_control` low for ≥1 cycle between runs.

Source files
------------

// File: rtl/div_sequencer_if.sv
// Signal bundle between the CPU control unit, the div_sequencer and the multicycle div datapath.
// The slave modport is the sequencer's view; the master modport is the view of the surrounding logic.
interface div_sequencer_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_control;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_err;

    modport slave (
        input  start, dividend, divisor, div_hi, div_lo, div_err,
        output busy, done, div_by_zero, hi, lo, div_control, div_a, div_b
    );

    modport master (
        output start, dividend, divisor, div_hi, div_lo, div_err,
        input  busy, done, div_by_zero, hi, lo, div_control, div_a, div_b
    );
endinterface

// File: rtl/div_sequencer.sv
// Sequences the unsigned multicycle divider for signed DIV: feeds magnitudes, holds divControl
// for DIV_CYCLES cycles, then sign-corrects the quotient/remainder into HI/LO.
module div_sequencer #(
    parameter int DIV_CYCLES = 33
) (
    input  logic            clk,
    input  logic            reset,
    div_sequencer_if.slave  sif
);
    localparam int CNT_W = $clog2(DIV_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CAPTURE,
        FINISH,
        ZERO
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ctrl_q, ctrl_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                ctrl_d = 1'b0;
                if (sif.start) begin
                    // 0x80000000 negates to itself, which the divider reads as unsigned 2^31
                    a_d     = sif.dividend[31] ? (32'd0 - sif.dividend) : sif.dividend;
                    b_d     = sif.divisor[31]  ? (32'd0 - sif.divisor)  : sif.divisor;
                    neg_q_d = sif.dividend[31] ^ sif.divisor[31];
                    neg_r_d = sif.dividend[31];
                    cnt_d   = '0;
                    ctrl_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sif.div_err && (cnt_q == CNT_W'(1))) begin
                    ctrl_d  = 1'b0;
                    state_d = ZERO;
                end else if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                    ctrl_d  = 1'b0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                lo_d    = neg_q_q ? (32'd0 - sif.div_lo) : sif.div_lo;
                hi_d    = neg_r_q ? (32'd0 - sif.div_hi) : sif.div_hi;
                cnt_d   = '0;
                state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            ZERO: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                ctrl_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign sif.busy        = (state_q == RUN) || (state_q == CAPTURE);
    assign sif.done        = (state_q == FINISH) || (state_q == ZERO);
    assign sif.div_by_zero = (state_q == ZERO);
    assign sif.hi          = hi_q;
    assign sif.lo          = lo_q;
    assign sif.div_control = ctrl_q;
    assign sif.div_a       = a_q;
    assign sif.div_b       = b_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural model of the unsigned multicycle divider.
module tb_div_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cycleCount = 0;

    div_sequencer_if sif ();

    div_sequencer #(.DIV_CYCLES(33)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Divider model: writes results on the 33rd enabled edge, flags err after the first enabled edge
    logic [5:0] modelCnt = '0;
    always @(posedge clk) begin
        if (!sif.div_control) begin
            modelCnt    <= '0;
            sif.div_err <= 1'b0;
        end else begin
            modelCnt <= modelCnt + 6'd1;
            if (modelCnt == 6'd0 && sif.div_b == 32'd0) sif.div_err <= 1'b1;
            if (modelCnt == 6'd32 && sif.div_b != 32'd0) begin
                sif.div_lo <= sif.div_a / sif.div_b;
                sif.div_hi <= sif.div_a % sif.div_b;
            end
        end
    end

    typedef struct {
        int          acc;
        int          lat;
        int          ctrlCyc;
        int          busyCyc;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] a;
        logic [31:0] b;
        logic        dbz;
    } exp_t;

    exp_t        q[$];
    int          compareCount = 0;
    int          mismatchCount = 0;
    logic [31:0] lastHi = '0;
    logic [31:0] lastLo = '0;
    int          busyCnt = 0;
    int          ctrlCnt = 0;
    int          abBad = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycleCount);
        end
    endtask

    function automatic exp_t makeEntry(input logic [31:0] x, input logic [31:0] y, input int acc);
        exp_t e;
        logic signed [31:0] sx, sy;
        sx = x;
        sy = y;
        e.acc = acc;
        e.a   = x[31] ? (32'd0 - x) : x;
        e.b   = y[31] ? (32'd0 - y) : y;
        if (y == 32'd0) begin
            e.lo = lastLo;  e.hi = lastHi;  e.dbz = 1'b1;
            e.lat = 3;  e.ctrlCyc = 2;  e.busyCyc = 2;
        end else begin
            e.lo = sx / sy;  e.hi = sx % sy;  e.dbz = 1'b0;
            e.lat = 35;  e.ctrlCyc = 33;  e.busyCyc = 34;
            lastLo = e.lo;
            lastHi = e.hi;
        end
        return e;
    endfunction

    // Drive one start pulse from a falling edge and record what the accept should produce
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
        sif.start    = 1'b1;
        sif.dividend = x;
        sif.divisor  = y;
        q.push_back(makeEntry(x, y, cycleCount));
        @(negedge clk);
        sif.start = 1'b0;
    endtask

    task automatic waitIdle();
        int budget = 0;
        while (q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0) begin
            checkOutput("timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard on every done pulse
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            busyCnt = 0;  ctrlCnt = 0;  abBad = 0;
        end else begin
            if (sif.busy === 1'b1) busyCnt++;
            if (sif.div_control === 1'b1) begin
                ctrlCnt++;
                if (q.size() > 0 && (sif.div_a !== q[0].a || sif.div_b !== q[0].b)) abBad++;
            end
            if (sif.done === 1'b1) begin
                if (q.size() == 0) begin
                    checkOutput("spuriousDone", 1, 0);
                end else begin
                    e = q.pop_front();
                    checkOutput("latency", cycleCount - e.acc, e.lat);
                    checkOutput("lo", sif.lo, e.lo);
                    checkOutput("hi", sif.hi, e.hi);
                    checkOutput("divByZero", sif.div_by_zero, e.dbz);
                    checkOutput("busyAtDone", sif.busy, 0);
                    checkOutput("ctrlCycles", ctrlCnt, e.ctrlCyc);
                    checkOutput("busyCycles", busyCnt, e.busyCyc);
                    checkOutput("abStable", abBad, 0);
                end
                busyCnt = 0;  ctrlCnt = 0;  abBad = 0;
            end
        end
    end

    initial begin
        int n;
        sif.start    = 1'b0;
        sif.dividend = '0;
        sif.divisor  = '0;
        sif.div_hi   = '0;
        sif.div_lo   = '0;
        sif.div_err  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rstBusy", sif.busy, 0);
        checkOutput("rstDone", sif.done, 0);
        checkOutput("rstCtrl", sif.div_control, 0);
        checkOutput("rstHi", sif.hi, 0);
        checkOutput("rstLo", sif.lo, 0);
        checkOutput("rstDivA", sif.div_a, 0);
        checkOutput("rstDivB", sif.div_b, 0);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(32'd100, 32'd7);
        waitIdle();
        applyStimulus(-32'sd100, 32'd7);
        waitIdle();
        applyStimulus(32'd100, -32'sd7);
        waitIdle();
        applyStimulus(-32'sd100, -32'sd7);
        waitIdle();

        applyStimulus(32'd100, 32'd7);
        waitIdle();
        applyStimulus(32'd55, 32'd0);
        waitIdle();
        checkOutput("zeroHoldsHi", sif.hi, 32'd2);
        checkOutput("zeroHoldsLo", sif.lo, 32'd14);

        // Abort mid-run: reset sampled at the end of cycle E+10
        n = cycleCount;
        applyStimulus(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy", sif.busy, 0);
        checkOutput("abortCtrl", sif.div_control, 0);
        checkOutput("abortDone", sif.done, 0);
        checkOutput("abortHi", sif.hi, 0);
        checkOutput("abortLo", sif.lo, 0);
        checkOutput("abortEdge", cycleCount - n, 11);
        q.delete();
        lastHi = '0;
        lastLo = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(32'd9, 32'd3);
        waitIdle();

        // Second start during RUN must be ignored
        applyStimulus(32'd1000, 32'd7);
        repeat (4) @(negedge clk);
        sif.start    = 1'b1;
        sif.dividend = 32'd50;
        sif.divisor  = 32'd5;
        @(negedge clk);
        sif.start = 1'b0;
        waitIdle();
        repeat (5) @(negedge clk);

        // Start held high: accepts land every 36 cycles
        n = cycleCount;
        sif.start    = 1'b1;
        sif.dividend = 32'hFFFF_FFFF;
        sif.divisor  = 32'd1;
        for (int k = 0; k < 3; k++) q.push_back(makeEntry(32'hFFFF_FFFF, 32'd1, n + 36 * k));
        repeat (80) @(negedge clk);
        sif.start = 1'b0;
        waitIdle();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
